// File: rtl/gh_display_pkg.sv
// Shared display constants, lane colour table and note-slot record for the note highway.
package gh_display_pkg;

  localparam int DISP_COUNT_W = 10;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_BG    = 12'h222;
  localparam logic [11:0] COL_HIT   = 12'hFFF;

  // Index 0 is the rightmost element: 0F0, F00, FF0, 00F, F80, 0FF, F0F, 888.
  localparam logic [7:0][11:0] LANE_COLOR = {12'h888, 12'hF0F, 12'h0FF, 12'hF80,
                                             12'h00F, 12'hFF0, 12'hF00, 12'h0F0};

  typedef struct packed {
    logic                    valid;
    logic [DISP_COUNT_W-1:0] y;
  } note_slot_t;

  function automatic logic [11:0] lane_color(input logic [2:0] idx);
    return LANE_COLOR[idx];
  endfunction

endpackage

// File: rtl/gh_lane_slots.sv
// One lane of falling notes: slot storage, spawn, per-frame scroll, hit search and the
// note-pixel flag for the current beam position.
module gh_lane_slots
  import gh_display_pkg::*;
#(
  parameter int LANE_IDX    = 0,
  parameter int SLOTS       = 4,
  parameter int COUNT_W     = 10,
  parameter int V_ACTIVE    = 480,
  parameter int LANE_X0     = 160,
  parameter int LANE_W      = 64,
  parameter int NOTE_H      = 16,
  parameter int HIT_Y       = 432,
  parameter int HIT_WIN     = 16,
  parameter int SCROLL_STEP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COUNT_W-1:0] h_count,
  input  logic [COUNT_W-1:0] v_count,
  input  logic               frame_tick,
  input  logic               spawn_we,
  input  logic               hit_req,
  output logic               has_free,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               note_px
);

  localparam int XW    = COUNT_W + 1;
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [XW-1:0] X_LO   = XW'(LANE_X0 + LANE_IDX * LANE_W);
  localparam logic [XW-1:0] X_HI   = XW'(LANE_X0 + (LANE_IDX + 1) * LANE_W);
  localparam logic [XW-1:0] NOTE_X = XW'(NOTE_H);
  localparam logic [XW-1:0] WIN_LO = XW'(HIT_Y - HIT_WIN);
  localparam logic [XW-1:0] WIN_HI = XW'(HIT_Y + HIT_WIN);
  localparam logic [XW-1:0] STEP_X = XW'(SCROLL_STEP);
  localparam logic [XW-1:0] V_END  = XW'(V_ACTIVE);

  note_slot_t        slots_r [SLOTS];
  note_slot_t        slots_n [SLOTS];
  logic              free_found_s, hit_found_s, fall_s;
  logic [IDX_W-1:0]  free_idx_s, hit_idx_s;
  logic [XW-1:0]     hx_s, vx_s;

  assign hx_s     = XW'(h_count);
  assign vx_s     = XW'(v_count);
  assign has_free = free_found_s;

  function automatic logic [XW-1:0] ext_y(input note_slot_t s);
    return XW'(s.y);
  endfunction

  // Lowest free slot and lowest hit-eligible slot; descending scan lets low indices win.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    hit_found_s  = 1'b0;
    hit_idx_s    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      free_found_s = free_found_s | !slots_r[i].valid;
      free_idx_s   = !slots_r[i].valid ? IDX_W'(i) : free_idx_s;
      hit_found_s  = hit_found_s | (slots_r[i].valid && (ext_y(slots_r[i]) + NOTE_X > WIN_LO)
                                    && (ext_y(slots_r[i]) < WIN_HI));
      hit_idx_s    = (slots_r[i].valid && (ext_y(slots_r[i]) + NOTE_X > WIN_LO)
                      && (ext_y(slots_r[i]) < WIN_HI)) ? IDX_W'(i) : hit_idx_s;
    end
  end

  // Hit is judged on pre-scroll y; a slot being spawned is empty, so the cases never overlap.
  always_comb begin
    fall_s = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      slots_n[i] = slots_r[i];
      if (hit_req && hit_found_s && (hit_idx_s == IDX_W'(i))) begin
        slots_n[i].valid = 1'b0;
      end else if (frame_tick && slots_r[i].valid) begin
        if (ext_y(slots_r[i]) + STEP_X >= V_END) begin
          slots_n[i].valid = 1'b0;
          fall_s           = 1'b1;
        end else begin
          slots_n[i].y = DISP_COUNT_W'(ext_y(slots_r[i]) + STEP_X);
        end
      end else if (spawn_we && free_found_s && (free_idx_s == IDX_W'(i))) begin
        slots_n[i].valid = 1'b1;
        slots_n[i].y     = '0;
      end else begin
        slots_n[i] = slots_r[i];
      end
    end
  end

  // Note pixel flag for the current beam position.
  always_comb begin
    note_px = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      note_px = note_px | (slots_r[i].valid && (vx_s >= ext_y(slots_r[i]))
                           && (vx_s < ext_y(slots_r[i]) + NOTE_X));
    end
    note_px = note_px && (hx_s >= X_LO) && (hx_s < X_HI);
  end

  // Slot state and per-lane judgement pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slots_r[i] <= '0;
      end
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        slots_r[i] <= slots_n[i];
      end
      hit_pulse  <= hit_req && hit_found_s;
      miss_pulse <= fall_s || (hit_req && !hit_found_s);
    end
  end

endmodule

// File: rtl/gh_lane_renderer.sv
// Note-highway renderer: frame tick, button edge detect, lane instances and registered RGB mux.
// Optional hit-band flash per lane is enabled by defining HIT_FLASH_EN.
module gh_lane_renderer
  import gh_display_pkg::*;
#(
  parameter int LANES        = 5,
  parameter int SLOTS        = 4,
  parameter int COUNT_W      = 10,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int LANE_X0      = 160,
  parameter int LANE_W       = 64,
  parameter int NOTE_H       = 16,
  parameter int HIT_Y        = 432,
  parameter int HIT_WIN      = 16,
  parameter int SCROLL_STEP  = 2,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNT_W-1:0]       h_count,
  input  logic [COUNT_W-1:0]       v_count,
  input  logic                     spawn_valid,
  input  logic [$clog2(LANES)-1:0] spawn_lane,
  output logic                     spawn_ready,
  input  logic [LANES-1:0]         hit_btn,
  output logic [LANES-1:0]         hit_pulse,
  output logic [LANES-1:0]         miss_pulse,
  output logic                     frame_tick,
  output logic [11:0]              rgb
);

  localparam int XW      = COUNT_W + 1;
  localparam int LIDX_W  = $clog2(LANES);
  localparam int PAD_W   = 1 << LIDX_W;
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [XW-1:0] H_END   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] V_END   = XW'(V_ACTIVE);
  localparam logic [XW-1:0] LX_LO   = XW'(LANE_X0);
  localparam logic [XW-1:0] LX_HI   = XW'(LANE_X0 + LANES * LANE_W);
  localparam logic [XW-1:0] BAND_LO = XW'(HIT_Y);
  localparam logic [XW-1:0] BAND_HI = XW'(HIT_Y + 2);

  logic [LANES-1:0]              btn_prev_r, hit_req_s, has_free_s, note_px_s, flash_on_s;
  logic [PAD_W-1:0]              free_pad_s;
  logic [LANES-1:0][FLASH_W-1:0] flash_r;
  logic [XW-1:0]                 hx_s, vx_s;
  logic                          in_lanes_s, in_band_s;
  logic [11:0]                   note_col_s, band_col_s, rgb_n_s;

  assign hx_s        = XW'(h_count);
  assign vx_s        = XW'(v_count);
  assign hit_req_s   = hit_btn & ~btn_prev_r;
  assign free_pad_s  = PAD_W'(has_free_s);
  assign spawn_ready = (32'(spawn_lane) < LANES) && free_pad_s[spawn_lane];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gh_lane_slots #(
      .LANE_IDX(l), .SLOTS(SLOTS), .COUNT_W(COUNT_W), .V_ACTIVE(V_ACTIVE),
      .LANE_X0(LANE_X0), .LANE_W(LANE_W), .NOTE_H(NOTE_H), .HIT_Y(HIT_Y),
      .HIT_WIN(HIT_WIN), .SCROLL_STEP(SCROLL_STEP)
    ) u_slots (
      .clk        (clk),
      .rst_n      (rst_n),
      .h_count    (h_count),
      .v_count    (v_count),
      .frame_tick (frame_tick),
      .spawn_we   (spawn_valid && spawn_ready && (32'(spawn_lane) == l)),
      .hit_req    (hit_req_s[l]),
      .has_free   (has_free_s[l]),
      .hit_pulse  (hit_pulse[l]),
      .miss_pulse (miss_pulse[l]),
      .note_px    (note_px_s[l])
    );
    assign flash_on_s[l] = |flash_r[l];
  end

`ifdef HIT_FLASH_EN
  // Per-lane flash countdown: reload on a hit, count down once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_r <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (hit_pulse[l]) begin
          flash_r[l] <= FLASH_W'(FLASH_FRAMES);
        end else if (frame_tick && (flash_r[l] != '0)) begin
          flash_r[l] <= flash_r[l] - FLASH_W'(1);
        end else begin
          flash_r[l] <= flash_r[l];
        end
      end
    end
  end
`else
  assign flash_r = '0;
`endif

  // Pixel colour: outside active area, then notes, then hit band, then lane background.
  always_comb begin
    in_lanes_s = (hx_s >= LX_LO) && (hx_s < LX_HI);
    in_band_s  = (vx_s >= BAND_LO) && (vx_s < BAND_HI);
    note_col_s = COL_BLACK;
    band_col_s = COL_HIT;
    for (int l = 0; l < LANES; l++) begin
      note_col_s = note_px_s[l] ? lane_color(3'(l)) : note_col_s;
      band_col_s = (flash_on_s[l] && (hx_s >= XW'(LANE_X0 + l * LANE_W))
                    && (hx_s < XW'(LANE_X0 + (l + 1) * LANE_W))) ? lane_color(3'(l)) : band_col_s;
    end
    if (!((hx_s < H_END) && (vx_s < V_END))) begin
      rgb_n_s = COL_BLACK;
    end else if (|note_px_s) begin
      rgb_n_s = note_col_s;
    end else if (in_band_s && in_lanes_s) begin
      rgb_n_s = band_col_s;
    end else if (in_lanes_s) begin
      rgb_n_s = COL_BG;
    end else begin
      rgb_n_s = COL_BLACK;
    end
  end

  // Frame tick, button history and the pixel output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      btn_prev_r <= '0;
      rgb        <= COL_BLACK;
    end else begin
      frame_tick <= (h_count == '0) && (v_count == COUNT_W'(V_ACTIVE));
      btn_prev_r <= hit_btn;
      rgb        <= rgb_n_s;
    end
  end

endmodule

// File: tb/tb_gh_lane_renderer.sv
// Directed self-checking bench for gh_lane_renderer with default parameters.
module tb_gh_lane_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_count, v_count;
  logic        spawn_valid;
  logic [2:0]  spawn_lane;
  logic        spawn_ready;
  logic [4:0]  hit_btn, hit_pulse, miss_pulse;
  logic        frame_tick;
  logic [11:0] rgb;

  int checks = 0;
  int failures = 0;
  int miss0_seen = 0;

  always #5 clk = ~clk;

  gh_lane_renderer dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .hit_btn(hit_btn), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .frame_tick(frame_tick), .rgb(rgb)
  );

  always @(negedge clk) begin
    if (rst_n && miss_pulse[0]) miss0_seen++;
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    h_count = 10'd0;
    v_count = 10'd480;
    tick();
    h_count = 10'd700;
    v_count = 10'd0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic pix(input int x, input int y, output logic [11:0] c);
    h_count = 10'(x);
    v_count = 10'(y);
    tick();
    c = rgb;
    h_count = 10'd700;
    v_count = 10'd0;
  endtask

  task automatic spawn(input int lane);
    spawn_lane  = 3'(lane);
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
  endtask

  logic [11:0] c;
  logic [4:0]  acc;
  int          snap;
  logic [11:0] band_after_hit;

  initial begin
`ifdef HIT_FLASH_EN
    band_after_hit = 12'hFF0;
`else
    band_after_hit = 12'hFFF;
`endif
    rst_n = 1'b0; h_count = 10'd700; v_count = 10'd0;
    spawn_valid = 1'b0; spawn_lane = 3'd0; hit_btn = 5'd0;
    repeat (2) tick();
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hit", {7'd0, hit_pulse}, 12'h000);
    chk("rst_miss", {7'd0, miss_pulse}, 12'h000);
    chk("rst_ftick", {11'd0, frame_tick}, 12'h000);
    chk("rst_ready", {11'd0, spawn_ready}, 12'h001);
    rst_n = 1'b1;
    tick();

    pix(160, 100, c); chk("bg_lane_left", c, 12'h222);
    pix(159, 100, c); chk("left_of_lanes", c, 12'h000);
    pix(479, 100, c); chk("bg_lane_right", c, 12'h222);
    pix(480, 100, c); chk("right_of_lanes", c, 12'h000);
    pix(200, 432, c); chk("band_top", c, 12'hFFF);
    pix(200, 433, c); chk("band_bot", c, 12'hFFF);
    pix(200, 434, c); chk("below_band", c, 12'h222);
    pix(200, 431, c); chk("above_band", c, 12'h222);
    pix(200, 480, c); chk("outside_v", c, 12'h000);

    h_count = 10'd0; v_count = 10'd480; tick();
    chk("ftick_high", {11'd0, frame_tick}, 12'h001);
    h_count = 10'd700; v_count = 10'd0; tick();
    chk("ftick_low", {11'd0, frame_tick}, 12'h000);

    // lane 2 note falls to the hit band and is hit
    spawn_lane = 3'd2; spawn_valid = 1'b1; #1;
    chk("ready_lane2", {11'd0, spawn_ready}, 12'h001);
    tick(); spawn_valid = 1'b0;
    pix(300, 0, c);  chk("note2_top", c, 12'hFF0);
    pix(300, 15, c); chk("note2_last", c, 12'hFF0);
    pix(300, 16, c); chk("note2_below", c, 12'h222);
    frames(216);
    pix(300, 432, c); chk("note2_at_band", c, 12'hFF0);
    pix(300, 448, c); chk("note2_end", c, 12'h222);
    hit_btn = 5'b00100; tick();
    chk("hit2_pulse", {7'd0, hit_pulse}, 12'h004);
    chk("hit2_nomiss", {7'd0, miss_pulse}, 12'h000);
    tick();
    chk("hit2_once", {7'd0, hit_pulse}, 12'h000);
    hit_btn = 5'd0;
    pix(300, 432, c); chk("band2_after_hit", c, band_after_hit);
    pix(300, 440, c); chk("note2_gone", c, 12'h222);

    // lane 3 window boundary: y=400 is too early, y=402 is in the window
    spawn(3);
    frames(200);
    pix(360, 400, c); chk("note3_top", c, 12'h00F);
    pix(360, 399, c); chk("note3_above", c, 12'h222);
    hit_btn = 5'b01000; tick();
    chk("early_miss3", {7'd0, miss_pulse}, 12'h008);
    chk("early_nohit3", {7'd0, hit_pulse}, 12'h000);
    hit_btn = 5'd0; tick();
    frames(1);
    hit_btn = 5'b01000; tick();
    chk("late_hit3", {7'd0, hit_pulse}, 12'h008);
    chk("late_nomiss3", {7'd0, miss_pulse}, 12'h000);
    hit_btn = 5'd0; tick();

    // lane 0 fill and out-of-range lane
    spawn_lane = 3'd0; spawn_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; chk("fill_ready", {11'd0, spawn_ready}, 12'h001);
      tick();
    end
    #1; chk("full_ready", {11'd0, spawn_ready}, 12'h000);
    spawn_lane = 3'd7; #1;
    chk("bad_lane_ready", {11'd0, spawn_ready}, 12'h000);
    spawn_valid = 1'b0;

    // bad press on lane 1, then hold
    hit_btn = 5'b00010; tick();
    chk("bad_press_miss1", {7'd0, miss_pulse}, 12'h002);
    acc = 5'd0;
    for (int k = 0; k < 100; k++) begin
      tick();
      acc = acc | hit_pulse | miss_pulse;
    end
    chk("hold_no_repeat", {7'd0, acc}, 12'h000);
    hit_btn = 5'd0; tick();

    // lane 0 notes fall off after 240 frames with a single miss pulse
    snap = miss0_seen;
    frames(239);
    chk("no_early_fall", 12'(miss0_seen - snap), 12'h000);
    pix(170, 478, c); chk("note0_bottom", c, 12'h0F0);
    spawn_lane = 3'd0; #1;
    chk("lane0_still_full", {11'd0, spawn_ready}, 12'h000);
    frames(1);
    tick();
    chk("fall_one_miss", 12'(miss0_seen - snap), 12'h001);
    chk("lane0_freed", {11'd0, spawn_ready}, 12'h001);
    frames(2);
    chk("fall_no_more", 12'(miss0_seen - snap), 12'h001);

    // reset mid-frame with notes live
    spawn(0); spawn(1); spawn(3);
    spawn(4); spawn(4); spawn(4); spawn(4);
    frames(5);
    pix(170, 12, c); chk("pre_rst_note0", c, 12'h0F0);
    spawn_lane = 3'd4; #1;
    chk("pre_rst_lane4_full", {11'd0, spawn_ready}, 12'h000);
    h_count = 10'd170; v_count = 10'd12;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rgb", rgb, 12'h000);
    chk("midrst_ready", {11'd0, spawn_ready}, 12'h001);
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty0", rgb, 12'h222);
    pix(430, 12, c); chk("post_rst_empty4", c, 12'h222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
